// File: rtl/loop_ddr4_reg_target.sv
// ---------------------------------------------------------------------------
// loop_ddr4_reg_target
// DDR4-side register target for the loop plugin (ddr4_ui_clk domain).
// Takes single-cycle write strobes from the box-to-DDR4 register crossing,
// holds the loop test control registers, sequences one command at a time to
// the DDR4 traffic engine over valid/ready, and drives the registered
// read-back bus returned across the crossing.
//
// State table
//   state | meaning
//   IDLE  | no command outstanding, accepts START
//   ISSUE | cmd_valid asserted, waiting for cmd_ready
//   WAIT  | command accepted, waiting for eng_done
//
// Register map (reg i at DDR4_RD_REG_BASE + i*DDR4_RD_REG_INC)
//   0 CTRL (write: [0] START, [1] CLEAR) / STATUS (read)
//   1 BASE_ADDR
//   2 LEN
//   3 {ERR_CNT[15:0], DONE_CNT[15:0]} (read only)
//
// Ports
//   ddr4_ui_clk     DDR4 UI clock
//   ddr4_ui_rst     hard reset, synchronous, active-high
//   ddr4_reg_rst    soft reset pulse, same effect as ddr4_ui_rst
//   ddr4_reg_we     write strobe, one cycle per host write
//   ddr4_reg_addr   write address (valid with ddr4_reg_we)
//   ddr4_reg_wdata  write data (valid with ddr4_reg_we)
//   ddr4_reg_rdata  read-back bus, reg i at [32*i +: 32]
//   cmd_valid       command valid to traffic engine
//   cmd_ready       engine accepts command
//   cmd_addr        DDR4 start address of the command
//   cmd_len         beat count of the command (never 0 while cmd_valid)
//   eng_done        one-cycle completion pulse from engine
//   eng_err         error flag, sampled with eng_done
// ---------------------------------------------------------------------------
module loop_ddr4_reg_target #(
  parameter int                    REG_ADDR_W       = 12,
  parameter int                    DDR4_NUM_RD_REGS = 4,
  parameter logic [REG_ADDR_W-1:0] DDR4_RD_REG_BASE = 12'h4,
  parameter logic [REG_ADDR_W-1:0] DDR4_RD_REG_INC  = 12'h4
) (
  input  logic                          ddr4_ui_clk,
  input  logic                          ddr4_ui_rst,
  input  logic                          ddr4_reg_rst,
  input  logic                          ddr4_reg_we,
  input  logic [REG_ADDR_W-1:0]         ddr4_reg_addr,
  input  logic [31:0]                   ddr4_reg_wdata,
  output logic [DDR4_NUM_RD_REGS*32-1:0] ddr4_reg_rdata,
  output logic                          cmd_valid,
  input  logic                          cmd_ready,
  output logic [31:0]                   cmd_addr,
  output logic [31:0]                   cmd_len,
  input  logic                          eng_done,
  input  logic                          eng_err
);

  localparam int RD_W = DDR4_NUM_RD_REGS * 32;

  localparam logic [REG_ADDR_W-1:0] ADDR_CTRL = DDR4_RD_REG_BASE;
  localparam logic [REG_ADDR_W-1:0] ADDR_BASE = DDR4_RD_REG_BASE + DDR4_RD_REG_INC;
  localparam logic [REG_ADDR_W-1:0] ADDR_LEN  = DDR4_RD_REG_BASE + DDR4_RD_REG_INC
                                              + DDR4_RD_REG_INC;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } state_t;

  state_t           state_q,     state_d;
  logic [31:0]      base_q,      base_d;
  logic [31:0]      len_q,       len_d;
  logic [31:0]      cmd_addr_q,  cmd_addr_d;
  logic [31:0]      cmd_len_q,   cmd_len_d;
  logic             cmd_valid_q, cmd_valid_d;
  logic [15:0]      done_cnt_q,  done_cnt_d;
  logic [15:0]      err_cnt_q,   err_cnt_d;
  logic             overrun_q,   overrun_d;
  logic             bad_len_q,   bad_len_d;
  logic             last_err_q,  last_err_d;
  logic [RD_W-1:0]  rdata_q,     rdata_d;

  logic        rst;
  logic        wr_ctrl;
  logic        wr_base;
  logic        wr_len;
  logic        start;
  logic        clear;
  logic        set_overrun;
  logic        set_bad_len;
  logic [31:0] status;

  assign rst     = ddr4_ui_rst | ddr4_reg_rst;
  assign wr_ctrl = ddr4_reg_we && (ddr4_reg_addr == ADDR_CTRL);
  assign wr_base = ddr4_reg_we && (ddr4_reg_addr == ADDR_BASE);
  assign wr_len  = ddr4_reg_we && (ddr4_reg_addr == ADDR_LEN);
  assign start   = wr_ctrl & ddr4_reg_wdata[0];
  assign clear   = wr_ctrl & ddr4_reg_wdata[1];

  assign status = {26'd0, state_q, last_err_q, bad_len_q, overrun_q,
                   (state_q != ST_IDLE)};

  always_comb begin
    state_d     = state_q;
    base_d      = base_q;
    len_d       = len_q;
    cmd_addr_d  = cmd_addr_q;
    cmd_len_d   = cmd_len_q;
    done_cnt_d  = done_cnt_q;
    err_cnt_d   = err_cnt_q;
    last_err_d  = last_err_q;
    set_overrun = 1'b0;
    set_bad_len = 1'b0;

    if (wr_base) base_d = ddr4_reg_wdata;
    if (wr_len)  len_d  = ddr4_reg_wdata;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (len_q != 32'd0) begin
            // Snapshot so later BASE/LEN writes cannot disturb the command.
            cmd_addr_d = base_q;
            cmd_len_d  = len_q;
            state_d    = ST_ISSUE;
          end else begin
            set_bad_len = 1'b1;
          end
        end
      end
      ST_ISSUE: begin
        if (start) set_overrun = 1'b1;
        if (cmd_valid_q && cmd_ready) state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (start) set_overrun = 1'b1;
        if (eng_done) begin
          state_d    = ST_IDLE;
          last_err_d = eng_err;
          if (done_cnt_q != 16'hFFFF) done_cnt_d = done_cnt_q + 16'd1;
          if (eng_err && (err_cnt_q != 16'hFFFF)) err_cnt_d = err_cnt_q + 16'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // CLEAR overrides a same-cycle count, but stickies raised by a
    // same-cycle START survive because clear is applied before start.
    if (clear) begin
      done_cnt_d = 16'd0;
      err_cnt_d  = 16'd0;
    end
    overrun_d = (clear ? 1'b0 : overrun_q) | set_overrun;
    bad_len_d = (clear ? 1'b0 : bad_len_q) | set_bad_len;

    cmd_valid_d = (state_d == ST_ISSUE);

    rdata_d = {err_cnt_q, done_cnt_q, len_q, base_q, status};
  end

  always_ff @(posedge ddr4_ui_clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      base_q      <= 32'd0;
      len_q       <= 32'd0;
      cmd_addr_q  <= 32'd0;
      cmd_len_q   <= 32'd0;
      cmd_valid_q <= 1'b0;
      done_cnt_q  <= 16'd0;
      err_cnt_q   <= 16'd0;
      overrun_q   <= 1'b0;
      bad_len_q   <= 1'b0;
      last_err_q  <= 1'b0;
      rdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      base_q      <= base_d;
      len_q       <= len_d;
      cmd_addr_q  <= cmd_addr_d;
      cmd_len_q   <= cmd_len_d;
      cmd_valid_q <= cmd_valid_d;
      done_cnt_q  <= done_cnt_d;
      err_cnt_q   <= err_cnt_d;
      overrun_q   <= overrun_d;
      bad_len_q   <= bad_len_d;
      last_err_q  <= last_err_d;
      rdata_q     <= rdata_d;
    end
  end

  assign cmd_valid      = cmd_valid_q;
  assign cmd_addr       = cmd_addr_q;
  assign cmd_len        = cmd_len_q;
  assign ddr4_reg_rdata = rdata_q;

endmodule
